nasti_stream_req_splitter: RTL
==============================

// Module: nasti_stream_req_splitter
// PURPOSE
//  Command front end of the NASTI-to-stream data mover.
//  - Accepts one large DMA read command (byte address and length) and splits it into
//    a sequence of mover requests.
//  - No request crosses a BOUNDARY-byte address boundary or exceeds MAX_CHUNK bytes.
//  - Drives the mover's r_valid/r_ready request port and returns a done or error
//    pulse per command.
// PARAMETERS
//  ADDR_WIDTH  64    width of addresses and lengths, in bytes
//  DATA_WIDTH  64    mover data width; alignment unit is DATA_WIDTH/8 bytes
//  DEST_WIDTH  1     width of the stream TDEST tag
//  USER_WIDTH  1     width of the stream TUSER tag
//  BOUNDARY    4096  power of two; no chunk crosses a multiple of this value
//  MAX_CHUNK   4096  power of two, <= BOUNDARY; maximum bytes per chunk
// PORTS
//  aclk       in   1           clock
//  areset     in   1           asynchronous reset, active-high
//  cmd_valid  in   1           command valid
//  cmd_ready  out  1           command accepted while cmd_valid && cmd_ready
//  cmd_addr   in   ADDR_WIDTH  start byte address
//  cmd_len    in   ADDR_WIDTH  length in bytes
//  cmd_dest   in   DEST_WIDTH  TDEST for every chunk of the command
//  cmd_user   in   USER_WIDTH  TUSER for every chunk of the command
//  cmd_last   in   1           command ends a stream packet
//  m_valid    out  1           chunk request valid (to mover r_valid)
//  m_ready    in   1           mover completion pulse (from mover r_ready)
//  m_addr     out  ADDR_WIDTH  chunk address
//  m_len      out  ADDR_WIDTH  chunk length in bytes
//  m_dest     out  DEST_WIDTH  copy of cmd_dest
//  m_user     out  USER_WIDTH  copy of cmd_user
//  m_last     out  1           cmd_last && (this is the final chunk)
//  done       out  1           one-cycle pulse: command completed
//  err        out  1           one-cycle pulse: command rejected as misaligned
//  busy       out  1           high whenever state != IDLE
// BEHAVIOUR
//  Reset values (async): state=IDLE; m_valid, done, err and busy are 0;
//  m_addr, m_len, m_dest, m_user and m_last are 0. All outputs are registered except
//  cmd_ready, which equals (state==IDLE).
//  States:
//   IDLE -> ISSUE on a command accept with cmd_len!=0 and cmd_addr and cmd_len both
//     aligned to DATA_WIDTH/8. The block latches addr, remaining length, dest, user
//     and last, and sets m_valid=1 with the first chunk on the next cycle.
//   ISSUE: m_valid and all m_* outputs stay stable until m_ready=1.
//     - On m_ready, if remaining!=0: the next chunk appears on m_* the following
//       cycle and m_valid stays 1 (back-to-back). This is required because the mover
//       re-samples r_valid in its IDLE cycle.
//     - On m_ready, if remaining==0: m_valid=0 next cycle, done=1 for one cycle, and
//       the state returns to IDLE.
//  Chunk computation, in ADDR_WIDTH-bit unsigned arithmetic:
//   - room  = BOUNDARY - (addr & (BOUNDARY-1))
//   - chunk = min(remaining, room, MAX_CHUNK)
//   - addr += chunk; remaining -= chunk
//   - The chunk for the next request is computed in the same cycle as the m_ready
//     handshake. The pipeline may hold it in a precomputed register.
//   - A chunk is always a nonzero multiple of DATA_WIDTH/8.
//   - addr + chunk wraps modulo 2^ADDR_WIDTH without any flag.
//  m_last=1 only on the final chunk, and only when cmd_last=1.
//  Zero-length command: accepted; done pulses the cycle after the accept; m_valid
//  never rises.
//  Misaligned command (cmd_addr or cmd_len not a multiple of DATA_WIDTH/8):
//  accepted; err pulses the cycle after the accept; done does not pulse; m_valid
//  never rises.
//  A zero-length command with a misaligned cmd_addr reports err, not done.
//  m_ready while m_valid=0 is ignored. err and done are never high in the same cycle.
//  Latency:
//   - Accept to first m_valid: 1 cycle.
//   - m_ready to done: 1 cycle.
//   - Accept to next cmd_ready: at least 2 cycles.
//  Reset mid-operation: m_valid drops immediately and the state returns to IDLE.
//  areset must also reset the mover, because the splitter does not drain in-flight
//  bursts.
// TESTING
//  1 cmd addr=0x0FF0 len=0x30 last=1 -> chunks (0x0FF0,0x10,m_last=0),
//    (0x1000,0x20,m_last=1); done one cycle after the 2nd m_ready.
//  2 addr=0x0 len=0x3000 last=0 -> 3 chunks of 0x1000 at 0x0/0x1000/0x2000, all
//    m_last=0; back-to-back m_valid with no low cycle.
//  3 len=0 -> done pulses exactly 1 cycle after accept; m_valid never 1.
//  4 addr=0x4 len=0x10 -> err pulse; no m_valid; cmd_ready high again 1 cycle later.
//  5 hold m_ready=0 for 100 cycles mid-command -> m_* stable; cmd_ready=0; busy=1.
//  6 assert areset while in ISSUE -> m_valid=0 in the same cycle; next command after
//    release starts cleanly.

Source files
------------

// File: rtl/nasti_stream_req_splitter.sv
// Command front end of the NASTI-to-stream data mover: splits one DMA read command
// into boundary-safe, size-capped mover requests and reports done/err per command.
module nasti_stream_req_splitter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned BOUNDARY   = 4096,
    parameter int unsigned MAX_CHUNK  = 4096
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [DEST_WIDTH-1:0] cmd_dest,
    input  logic [USER_WIDTH-1:0] cmd_user,
    input  logic                  cmd_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [ADDR_WIDTH-1:0] m_len,
    output logic [DEST_WIDTH-1:0] m_dest,
    output logic [USER_WIDTH-1:0] m_user,
    output logic                  m_last,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned ALIGN_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(ALIGN_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BOUND_V    = ADDR_WIDTH'(BOUNDARY);
    localparam logic [ADDR_WIDTH-1:0] BOUND_MASK = ADDR_WIDTH'(BOUNDARY - 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_V      = ADDR_WIDTH'(MAX_CHUNK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    m_valid_q, m_valid_d;
    logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
    logic [ADDR_WIDTH-1:0]   m_len_q, m_len_d;
    logic [DEST_WIDTH-1:0]   m_dest_q, m_dest_d;
    logic [USER_WIDTH-1:0]   m_user_q, m_user_d;
    logic                    m_last_q, m_last_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
    logic                    last_q, last_d;

    logic [ADDR_WIDTH-1:0]   src_addr_c;
    logic [ADDR_WIDTH-1:0]   src_rem_c;
    logic [ADDR_WIDTH-1:0]   room_c;
    logic [ADDR_WIDTH-1:0]   chunk_c;
    logic                    cmd_misaligned_c;

    assign cmd_ready = (state_q == IDLE);
    assign m_valid   = m_valid_q;
    assign m_addr    = m_addr_q;
    assign m_len     = m_len_q;
    assign m_dest    = m_dest_q;
    assign m_user    = m_user_q;
    assign m_last    = m_last_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;

    assign cmd_misaligned_c = |((cmd_addr | cmd_len) & ALIGN_MASK);

    // One chunk calculator shared by the first chunk (from the command) and later ones.
    always_comb begin
        src_addr_c = (state_q == IDLE) ? cmd_addr : next_addr_q;
        src_rem_c  = (state_q == IDLE) ? cmd_len  : rem_q;
        room_c     = BOUND_V - (src_addr_c & BOUND_MASK);
        chunk_c    = src_rem_c;
        if (room_c < chunk_c) begin
            chunk_c = room_c;
        end
        if (MAX_V < chunk_c) begin
            chunk_c = MAX_V;
        end
    end

    always_comb begin
        state_d     = state_q;
        m_valid_d   = m_valid_q;
        m_addr_d    = m_addr_q;
        m_len_d     = m_len_q;
        m_dest_d    = m_dest_q;
        m_user_d    = m_user_q;
        m_last_d    = m_last_q;
        next_addr_d = next_addr_q;
        rem_d       = rem_q;
        last_d      = last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_misaligned_c) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (cmd_len == '0) begin
                        done_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        m_valid_d   = 1'b1;
                        m_addr_d    = cmd_addr;
                        m_len_d     = chunk_c;
                        m_dest_d    = cmd_dest;
                        m_user_d    = cmd_user;
                        m_last_d    = cmd_last && (cmd_len == chunk_c);
                        next_addr_d = cmd_addr + chunk_c;
                        rem_d       = cmd_len - chunk_c;
                        last_d      = cmd_last;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Next chunk follows the completion back-to-back so the mover sees r_valid held.
                if (m_ready) begin
                    if (rem_q != '0) begin
                        m_addr_d    = next_addr_q;
                        m_len_d     = chunk_c;
                        m_last_d    = last_q && (rem_q == chunk_c);
                        next_addr_d = next_addr_q + chunk_c;
                        rem_d       = rem_q - chunk_c;
                    end else begin
                        m_valid_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_len_q     <= '0;
            m_dest_q    <= '0;
            m_user_q    <= '0;
            m_last_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            next_addr_q <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            m_addr_q    <= m_addr_d;
            m_len_q     <= m_len_d;
            m_dest_q    <= m_dest_d;
            m_user_q    <= m_user_d;
            m_last_q    <= m_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            next_addr_q <= next_addr_d;
            rem_q       <= rem_d;
            last_q      <= last_d;
        end
    end

endmodule
